// File: rtl/rsa_host_ctrl.sv
// rtl/rsa_host_ctrl.sv - host-side byte-serial sequencer for the exp2_rsa register interface
module rsa_host_ctrl #(
    parameter int          RD_LAT  = 1,
    parameter logic [31:0] TIMEOUT = 32'd16777216
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_key,
    input  logic [255:0] key_hi,
    input  logic [255:0] key_lo,
    input  logic [255:0] msg,
    output logic         res_valid,
    output logic [255:0] res,
    output logic         err,
    output logic         busy,
    output logic         core_we,
    output logic         core_oe,
    output logic         core_start,
    output logic [1:0]   core_sel,
    output logic [4:0]   core_addr,
    output logic [7:0]   core_wdata,
    input  logic [7:0]   core_data,
    input  logic         core_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR3, S_WR2, S_WR1, S_START, S_WAIT, S_READ, S_DONE
    } state_t;

    localparam logic [5:0] RD_FIRST = 6'(RD_LAT);
    localparam logic [5:0] RD_LAST  = 6'(31 + RD_LAT);

    state_t         state, state_nx;
    logic [5:0]     cnt;
    logic [31:0]    wait_cnt;
    logic           low_seen;
    logic [255:0]   kh_r, kl_r, msg_r, res_r;
    logic [247:0]   rd_buf;
    logic [4:0]     rd_idx;

    // Read pipeline: byte index lags the issued address by RD_LAT (mod 32).
    assign rd_idx = cnt[4:0] - RD_FIRST[4:0];
    assign res    = res_r;

    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        core_we    = 1'b0;
        core_oe    = 1'b0;
        core_start = 1'b0;
        core_sel   = 2'd0;
        core_addr  = 5'd0;
        core_wdata = 8'd0;
        res_valid  = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nx = cmd_key ? S_WR3 : S_WR1;
            end
            S_WR3: begin
                core_we    = 1'b1;
                core_sel   = 2'd3;
                core_addr  = cnt[4:0];
                core_wdata = kh_r[{cnt[4:0], 3'b000} +: 8];
                if (cnt == 6'd31) state_nx = S_WR2;
            end
            S_WR2: begin
                core_we    = 1'b1;
                core_sel   = 2'd2;
                core_addr  = cnt[4:0];
                core_wdata = kl_r[{cnt[4:0], 3'b000} +: 8];
                if (cnt == 6'd31) state_nx = S_WR1;
            end
            S_WR1: begin
                core_we    = 1'b1;
                core_sel   = 2'd1;
                core_addr  = cnt[4:0];
                core_wdata = msg_r[{cnt[4:0], 3'b000} +: 8];
                if (cnt == 6'd31) state_nx = S_START;
            end
            S_START: begin
                core_start = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                // A genuine 0->1 edge wins over a coincident timeout.
                if (low_seen && core_ready) begin
                    state_nx = S_READ;
                end else if (wait_cnt == TIMEOUT) begin
                    err      = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_READ: begin
                core_oe = 1'b1;
                if (!cnt[5]) core_addr = cnt[4:0];
                if (cnt == RD_LAST) state_nx = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 6'd0;
            wait_cnt <= 32'd0;
            low_seen <= 1'b0;
            kh_r     <= '0;
            kl_r     <= '0;
            msg_r    <= '0;
            rd_buf   <= '0;
            res_r    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    cnt <= 6'd0;
                    if (cmd_valid) begin
                        kh_r  <= key_hi;
                        kl_r  <= key_lo;
                        msg_r <= msg;
                    end
                end
                S_WR3, S_WR2, S_WR1: cnt <= (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
                S_START: begin
                    wait_cnt <= 32'd0;
                    low_seen <= 1'b0;
                end
                S_WAIT: begin
                    cnt      <= 6'd0;
                    wait_cnt <= wait_cnt + 32'd1;
                    if (!core_ready) low_seen <= 1'b1;
                end
                S_READ: begin
                    cnt <= cnt + 6'd1;
                    if (cnt >= RD_FIRST) begin
                        // Last byte lands directly in res so it is valid during DONE.
                        if (cnt == RD_LAST) res_r <= {core_data, rd_buf};
                        else rd_buf[{rd_idx, 3'b000} +: 8] <= core_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
